// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between IF and the memory controller.
// Optional hit/miss performance counters are built when ICACHE_PERF_EN is defined.
module icache #(
  parameter int IDX_W = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic        if_done,
  output logic [31:0] if_instr,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_done,
  input  logic [31:0] mc_data,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int TAG_W = 16 - IDX_W;
  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [31:2]       req_addr_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [31:0]       data_r [LINES];

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  tag_s;
  logic              hit_s;
  logic              latch_s;
  logic              fill_s;
  logic              done_s;
  logic [31:0]       instr_s;
  logic              mc_req_s;
  logic [31:0]       mc_addr_s;
  logic              hit_inc_s;
  logic              miss_inc_s;
  logic              unused_addr_s;

  assign idx_s = req_addr_r[2+IDX_W-1:2];
  assign tag_s = req_addr_r[17:2+IDX_W];
  assign hit_s = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
  assign unused_addr_s = ^if_addr[1:0];

  // Next-state and registered-output next values; mc_req is only dropped on a completed fill.
  always_comb begin
    state_s    = state_r;
    latch_s    = 1'b0;
    fill_s     = 1'b0;
    done_s     = 1'b0;
    instr_s    = if_instr;
    mc_req_s   = mc_req;
    mc_addr_s  = mc_addr;
    hit_inc_s  = 1'b0;
    miss_inc_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (if_req && !flush) begin
          latch_s = 1'b1;
          state_s = LOOKUP;
        end else begin
          state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (flush) begin
          state_s = IDLE;
        end else if (hit_s) begin
          done_s    = 1'b1;
          instr_s   = data_r[idx_s];
          hit_inc_s = 1'b1;
          state_s   = IDLE;
        end else begin
          mc_req_s   = 1'b1;
          mc_addr_s  = {req_addr_r[31:2], 2'b00};
          miss_inc_s = 1'b1;
          state_s    = MISS;
        end
      end
      MISS: begin
        if (mc_done) begin
          fill_s   = 1'b1;
          mc_req_s = 1'b0;
          state_s  = IDLE;
          // A flush arriving with the fill still completes the line but suppresses the response.
          if (!flush) begin
            done_s  = 1'b1;
            instr_s = mc_data;
          end else begin
            done_s  = 1'b0;
          end
        end else if (flush) begin
          state_s = DROP;
        end else begin
          state_s = MISS;
        end
      end
      DROP: begin
        if (mc_done) begin
          fill_s   = 1'b1;
          mc_req_s = 1'b0;
          state_s  = IDLE;
        end else begin
          state_s  = DROP;
        end
      end
      default: begin
        state_s  = IDLE;
        mc_req_s = 1'b0;
      end
    endcase
  end

  // State, request address, valid bits and registered outputs; rdy_in low freezes everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r    <= IDLE;
      req_addr_r <= 30'd0;
      valid_r    <= {LINES{1'b0}};
      if_done    <= 1'b0;
      if_instr   <= 32'd0;
      mc_req     <= 1'b0;
      mc_addr    <= 32'd0;
    end else if (rdy_in) begin
      state_r  <= state_s;
      if_done  <= done_s;
      if_instr <= instr_s;
      mc_req   <= mc_req_s;
      mc_addr  <= mc_addr_s;
      if (latch_s) begin
        req_addr_r <= if_addr[31:2];
      end
      if (fill_s) begin
        valid_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_r alone qualifies their contents.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill_s) begin
      tag_r[idx_s]  <= tag_s;
      data_r[idx_s] <= mc_data;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  // Free-running hit/miss counters, wrapping modulo 2^32.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else if (rdy_in) begin
      if (hit_inc_s) begin
        hit_cnt_r <= hit_cnt_r + 32'd1;
      end
      if (miss_inc_s) begin
        miss_cnt_r <= miss_cnt_r + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
`else
  logic unused_perf_s;
  assign unused_perf_s = hit_inc_s ^ miss_inc_s;
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule
